// File: rtl/wb_serial_master_pkg.sv
// Shared definitions for the serial-to-Wishbone bridge: FSM state encoding,
// frame command bytes and response bytes.
package wb_serial_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;

  localparam logic [7:0] RSP_OK      = 8'h4B;
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;
  localparam logic [7:0] RSP_ERROR   = 8'h3F;

  // Longest response is the OK byte followed by four read-data bytes.
  localparam int RESP_MAX_BYTES = 5;
  localparam int RESP_BITS      = RESP_MAX_BYTES * 8;

endpackage

// File: rtl/wb_serial_master_if.sv
// Byte streams to/from the serial side plus the Wishbone classic master bus.
interface wb_serial_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  rx_data, rx_valid, tx_ready, wbm_ack_i, wbm_dat_i,
    output rx_ready, tx_data, tx_valid,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wbm_ack_i, wbm_dat_i,
    input  rx_ready, tx_data, tx_valid,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o
  );
endinterface

// File: rtl/wb_serial_master_resp_shifter.sv
// Response byte shifter: loads a response of one to five bytes and presents
// them MSB first on a valid/ready stream, one byte per accepted transfer.
module resp_shifter
  import wb_serial_master_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [RESP_BITS-1:0] i_loadData,
  input  logic [2:0]           i_loadCount,
  input  logic                 i_txReady,
  output logic [7:0]           o_txData,
  output logic                 o_txValid,
  output logic                 o_lastXfer
);

  logic [RESP_BITS-1:0] r_buf;
  logic [2:0]           r_count;
  logic                 w_xfer;

  assign o_txValid  = (r_count != 3'd0);
  assign w_xfer     = o_txValid && i_txReady;
  assign o_lastXfer = w_xfer && (r_count == 3'd1);
  assign o_txData   = r_buf[RESP_BITS-1 -: 8];

  // Hold the current byte while stalled; shift the next one up after each transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_buf   <= i_loadData;
      r_count <= i_loadCount;
    end else if (w_xfer) begin
      r_buf   <= {r_buf[RESP_BITS-9:0], 8'h00};
      r_count <= r_count - 3'd1;
    end
  end

endmodule

// File: rtl/wb_serial_master.sv
// Serial command bridge: parses write/read frames from a byte stream, runs one
// Wishbone classic cycle per frame (with an ack timeout) and streams back a
// status response plus read data.
module wb_serial_master
  import wb_serial_master_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  wb_serial_master_if.master         bus,
  output logic                       busy
);

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_alive;
  logic [1:0]            r_byteCnt;
  logic [15:0]           r_timer;
  logic                  r_we;
  logic                  r_cyc;
  logic [3:0]            r_sel;
  logic [31:0]           r_adr;
  logic [31:0]           r_dat;

  logic                  w_inRx;
  logic                  w_rxXfer;
  logic                  w_isCmd;
  logic                  w_ack;
  logic                  w_timeout;
  logic                  w_load;
  logic [RESP_BITS-1:0]  w_loadData;
  logic [2:0]            w_loadCount;
  logic                  w_lastXfer;

  assign w_inRx    = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign bus.rx_ready = w_inRx && r_alive;
  assign w_rxXfer  = bus.rx_valid && bus.rx_ready;
  assign w_isCmd   = (bus.rx_data == CMD_WRITE) || (bus.rx_data == CMD_READ);
  assign w_ack     = (r_state == ST_BUS) && bus.wbm_ack_i;
  assign w_timeout = (r_state == ST_BUS) && !bus.wbm_ack_i &&
                     (r_timer == 16'(ACK_TIMEOUT - 1));

  assign bus.wbm_cyc_o = r_cyc;
  assign bus.wbm_stb_o = r_cyc;
  assign bus.wbm_we_o  = r_we && r_cyc;
  assign bus.wbm_adr_o = r_adr;
  assign bus.wbm_dat_o = r_dat;
  assign bus.wbm_sel_o = r_sel;
  assign busy          = (r_state != ST_IDLE);

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_state <= ST_IDLE;
    else           r_state <= w_nextState;
  end

  // Keeps rx_ready low while in reset; it rises on the first clock after release
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_alive <= 1'b0;
    else           r_alive <= 1'b1;
  end

  // Next-state decode and the response to queue when a frame resolves
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_loadData  = '0;
    w_loadCount = 3'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_rxXfer) begin
          if (w_isCmd) begin
            w_nextState = ST_ADDR;
          end else begin
            w_nextState = ST_RESP;
            w_load      = 1'b1;
            w_loadData  = {RSP_ERROR, 32'h0};
            w_loadCount = 3'd1;
          end
        end
      end
      ST_ADDR: begin
        if (w_rxXfer && (r_byteCnt == 2'd3)) w_nextState = r_we ? ST_DATA : ST_BUS;
      end
      ST_DATA: begin
        if (w_rxXfer && (r_byteCnt == 2'd3)) w_nextState = ST_BUS;
      end
      ST_BUS: begin
        if (w_ack) begin
          w_nextState = ST_RESP;
          w_load      = 1'b1;
          w_loadData  = r_we ? {RSP_OK, 32'h0} : {RSP_OK, bus.wbm_dat_i};
          w_loadCount = r_we ? 3'd1 : 3'd5;
        end else if (w_timeout) begin
          w_nextState = ST_RESP;
          w_load      = 1'b1;
          w_loadData  = {RSP_TIMEOUT, 32'h0};
          w_loadCount = 3'd1;
        end
      end
      ST_RESP: begin
        if (w_lastXfer) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Frame capture: command type, byte position and the MSB-first address/data fields
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_we      <= 1'b0;
      r_byteCnt <= 2'd0;
      r_adr     <= 32'h0;
      r_dat     <= 32'h0;
    end else if (w_rxXfer) begin
      case (r_state)
        ST_IDLE: begin
          r_we      <= (bus.rx_data == CMD_WRITE);
          r_byteCnt <= 2'd0;
        end
        ST_ADDR: begin
          r_adr     <= {r_adr[23:0], bus.rx_data};
          r_byteCnt <= r_byteCnt + 2'd1;
        end
        ST_DATA: begin
          r_dat     <= {r_dat[23:0], bus.rx_data};
          r_byteCnt <= r_byteCnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Wishbone cycle control: raise cyc/stb on entry to BUS, drop on ack or timeout
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_cyc   <= 1'b0;
      r_sel   <= 4'h0;
      r_timer <= 16'h0;
    end else if ((r_state != ST_BUS) && (w_nextState == ST_BUS)) begin
      r_cyc   <= 1'b1;
      r_sel   <= 4'hF;
      r_timer <= 16'h0;
    end else if (r_state == ST_BUS) begin
      if (w_ack || w_timeout) begin
        r_cyc   <= 1'b0;
        r_sel   <= 4'h0;
        r_timer <= 16'h0;
      end else begin
        r_timer <= r_timer + 16'd1;
      end
    end
  end

  resp_shifter u_resp (
    .i_clk       (wb_clk_i),
    .i_rst_n     (wb_rst_i),
    .i_load      (w_load),
    .i_loadData  (w_loadData),
    .i_loadCount (w_loadCount),
    .i_txReady   (bus.tx_ready),
    .o_txData    (bus.tx_data),
    .o_txValid   (bus.tx_valid),
    .o_lastXfer  (w_lastXfer)
  );

endmodule

// File: tb/tb_wb_serial_master.sv
// Testbench for wb_serial_master: drives command frames, emulates a Wishbone
// slave with a programmable ack delay and collects the response stream, which
// is compared against a frame-level model of the bridge.
module tb_wb_serial_master;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rstN;
  logic busy;

  wb_serial_master_if bus ();

  wb_serial_master #(.ACK_TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rstN),
    .bus      (bus),
    .busy     (busy)
  );

  int compared   = 0;
  int mismatched = 0;
  int cycleCnt   = 0;

  logic [7:0] frameQ[$];
  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];

  int          monCycles;
  int          monUnstable;
  int          slaveAckDelay;
  logic [31:0] monAdr;
  logic [31:0] monDat;
  logic        monWe;
  logic [3:0]  monSel;

  int lastAccept;
  int firstValid;
  int holdErr;
  int sendStuck;

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index used for latency measurements
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Wishbone slave emulation: records the first-cycle bus values, flags any change
  // while the cycle is open, and acks on the programmed cycle of the transaction
  always @(negedge clk) begin
    if (bus.wbm_cyc_o === 1'b1) begin
      if (monCycles == 0) begin
        monAdr = bus.wbm_adr_o;
        monDat = bus.wbm_dat_o;
        monWe  = bus.wbm_we_o;
        monSel = bus.wbm_sel_o;
      end else if (bus.wbm_adr_o !== monAdr || bus.wbm_dat_o !== monDat ||
                   bus.wbm_we_o !== monWe || bus.wbm_sel_o !== monSel) begin
        monUnstable++;
      end
      if (bus.wbm_stb_o !== 1'b1) monUnstable++;
      monCycles++;
      bus.wbm_ack_i = (slaveAckDelay != 0) && (monCycles == slaveAckDelay);
    end else begin
      if (bus.wbm_stb_o === 1'b1) monUnstable++;
      bus.wbm_ack_i = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic buildFrame(input logic [7:0] cmd, input logic [31:0] adr,
                            input logic [31:0] dat);
    frameQ.delete();
    frameQ.push_back(cmd);
    if (cmd == 8'h57 || cmd == 8'h52)
      for (int i = 3; i >= 0; i--) frameQ.push_back(adr[i*8 +: 8]);
    if (cmd == 8'h57)
      for (int i = 3; i >= 0; i--) frameQ.push_back(dat[i*8 +: 8]);
  endtask

  // Serial source: offers each byte with random idle gaps, waits for rx_ready
  task automatic sendFrame();
    int waitCnt;
    int gap;
    for (int i = 0; i < frameQ.size(); i++) begin
      gap = $urandom_range(0, 2);
      bus.rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.rx_data  = frameQ[i];
      bus.rx_valid = 1'b1;
      waitCnt = 0;
      while (bus.rx_ready !== 1'b1 && waitCnt < 100) begin
        @(posedge clk); #1;
        waitCnt++;
      end
      if (waitCnt >= 100) begin
        sendStuck++;
        break;
      end
      lastAccept = cycleCnt;
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  // Serial sink: mode 0 always ready, 1 toggles ready each cycle, 2 random
  task automatic collectResp(input int mode, input int expN);
    int   waitCnt = 0;
    logic toggle  = 1'b1;
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;
    firstValid = -1;
    holdErr    = 0;
    while (gotQ.size() < expN && waitCnt < 300) begin
      case (mode)
        0:       bus.tx_ready = 1'b1;
        1:       begin bus.tx_ready = toggle; toggle = ~toggle; end
        default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.tx_valid === 1'b1) begin
        if (firstValid < 0) firstValid = cycleCnt;
        if (stalled && bus.tx_data !== held) holdErr++;
        if (bus.rx_ready !== 1'b0 || busy !== 1'b1) holdErr++;
        if (bus.tx_ready) begin
          gotQ.push_back(bus.tx_data);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = bus.tx_data;
        end
      end
      @(posedge clk); #1;
      waitCnt++;
    end
    bus.tx_ready = 1'b0;
  endtask

  // One complete frame: build it, predict the bridge's behaviour, run it and compare
  task automatic applyStimulus(input string name, input logic [7:0] cmd,
                               input logic [31:0] adr, input logic [31:0] dat,
                               input logic [31:0] rdData, input int ackDelay,
                               input int mode);
    bit isW;
    bit isR;
    bit acked;
    int expCycles;
    isW = (cmd == 8'h57);
    isR = (cmd == 8'h52);
    buildFrame(cmd, adr, dat);
    expQ.delete();
    gotQ.delete();
    if (!(isW || isR)) begin
      expQ.push_back(8'h3F);
      expCycles = 0;
    end else begin
      acked     = (ackDelay >= 1) && (ackDelay <= TMO);
      expCycles = acked ? ackDelay : TMO;
      if (!acked) expQ.push_back(8'h54);
      else begin
        expQ.push_back(8'h4B);
        if (isR) for (int i = 3; i >= 0; i--) expQ.push_back(rdData[i*8 +: 8]);
      end
    end

    monCycles     = 0;
    monUnstable   = 0;
    slaveAckDelay = ackDelay;
    bus.wbm_dat_i = rdData;
    sendStuck     = 0;

    fork
      sendFrame();
      collectResp(mode, expQ.size());
    join

    checkOutput($sformatf("%s rxStuck", name), sendStuck, 0);
    checkOutput($sformatf("%s respCount", name), gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      checkOutput($sformatf("%s resp[%0d]", name, i), gotQ[i], expQ[i]);
    checkOutput($sformatf("%s cycCycles", name), monCycles, expCycles);
    if (expCycles > 0) begin
      checkOutput($sformatf("%s adr", name), monAdr, adr);
      checkOutput($sformatf("%s we", name), monWe, isW);
      checkOutput($sformatf("%s sel", name), monSel, 4'hF);
      if (isW) checkOutput($sformatf("%s dat", name), monDat, dat);
    end
    checkOutput($sformatf("%s busStable", name), monUnstable, 0);
    checkOutput($sformatf("%s txHold", name), holdErr, 0);
    checkOutput($sformatf("%s latency", name), firstValid - lastAccept, 1 + expCycles);
    checkOutput($sformatf("%s idleAfter", name),
                {bus.tx_valid, busy, bus.rx_ready}, 3'b001);
  endtask

  // Directed sequence followed by randomized frames and a reset mid-cycle
  initial begin
    int waitCnt;
    rstN          = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.tx_ready  = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    monCycles     = 0;
    monUnstable   = 0;
    slaveAckDelay = 0;
    $display("[TB] start, ACK_TIMEOUT=%0d", TMO);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rx/tx/busy", {bus.rx_ready, bus.tx_valid, busy}, 3'b000);
    checkOutput("reset tx_data", bus.tx_data, 8'h00);
    checkOutput("reset cyc/stb/we", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 3'b000);
    checkOutput("reset adr", bus.wbm_adr_o, 32'h0);
    checkOutput("reset dat", bus.wbm_dat_o, 32'h0);
    checkOutput("reset sel", bus.wbm_sel_o, 4'h0);

    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("release rx_ready", bus.rx_ready, 1'b1);

    applyStimulus("write",      8'h57, 32'h30000004, 32'hDEADBEEF, 32'h0, 1, 0);
    applyStimulus("read",       8'h52, 32'h30800008, 32'h0, 32'h12345678, 1, 1);
    applyStimulus("readTmo",    8'h52, 32'h00001000, 32'h0, 32'hCAFEF00D, 0, 0);
    applyStimulus("badByte",    8'hA5, 32'h0, 32'h0, 32'h0, 1, 0);
    applyStimulus("ackAtLimit", 8'h57, 32'h11223344, 32'h55667788, 32'h0, TMO, 2);
    applyStimulus("ackTooLate", 8'h52, 32'h0000ABCD, 32'h0, 32'h87654321, TMO + 1, 0);

    for (int k = 0; k < 10; k++) begin
      logic [7:0] c;
      int r;
      r = $urandom_range(0, 9);
      c = (r < 4) ? 8'h57 : (r < 8) ? 8'h52 : 8'($urandom);
      applyStimulus($sformatf("rand%0d", k), c, $urandom, $urandom, $urandom,
                    $urandom_range(0, TMO + 2), $urandom_range(0, 2));
    end

    buildFrame(8'h57, 32'hA0000010, 32'h01020304);
    monCycles     = 0;
    slaveAckDelay = 0;
    sendStuck     = 0;
    sendFrame();
    waitCnt = 0;
    while (bus.wbm_cyc_o !== 1'b1 && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("midReset cycSeen", bus.wbm_cyc_o, 1'b1);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midReset cyc/stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b00);
    checkOutput("midReset busy/rx/tx", {busy, bus.rx_ready, bus.tx_valid}, 3'b000);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("midReset release", {bus.rx_ready, busy}, 2'b10);
    applyStimulus("postReset", 8'h57, 32'h40000020, 32'h0BADCAFE, 32'h0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_serial_master.md
WB_SERIAL_MASTER -- requirements
Module: wb_serial_master

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, is the max cycles a bus cycle waits for wbm_ack_i before abort (legal 1..65535).
REQ-002 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous release.
REQ-004 rx_data  in  8  command byte from serial receiver.
REQ-005 rx_valid  in  1  rx_data valid.
REQ-006 rx_ready  out  1  block accepts rx_data; transfer on rx_valid & rx_ready.
REQ-007 tx_data  out  8  response byte to serial transmitter.
REQ-008 tx_valid  out  1  tx_data valid.
REQ-009 tx_ready  in  1  transmitter accepts; transfer on tx_valid & tx_ready.
REQ-010 wbm_adr_o  out  32  Wishbone address; wbm_dat_o out 32 write data; wbm_sel_o out 4 byte select.
REQ-011 wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone classic master controls.
REQ-012 wbm_ack_i  in  1  slave ack; wbm_dat_i in 32 read data.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 Frames: write = 0x57 + 4 address bytes + 4 data bytes; read = 0x52 + 4 address bytes; multi-byte fields MSB first.
REQ-015 States: IDLE, ADDR, DATA, BUS, RESP; rx_ready SHALL be 1 exactly in IDLE, ADDR, DATA.
REQ-016 IDLE: 0x57/0x52 accepted -> latch we, clear byte counter, go ADDR; any other byte -> queue response 0x3F, go RESP.
REQ-017 ADDR: shift 4 accepted bytes into address; after 4th go DATA if write, else BUS; DATA likewise shifts 4 bytes then goes BUS.
REQ-018 Entry to BUS: the cycle after final byte acceptance, wbm_cyc_o = wbm_stb_o = 1, wbm_sel_o = 4'hF, wbm_adr_o/wbm_dat_o/wbm_we_o held stable until cycle ends.
REQ-019 On wbm_ack_i = 1 in BUS: cyc/stb low next cycle, wbm_dat_i latched if read, go RESP with response 0x4B (write) or 0x4B + 4 read-data bytes MSB first (read).
REQ-020 Timeout: 16-bit counter increments each BUS cycle without ack; at ACK_TIMEOUT counts, cyc/stb drop next cycle, response 0x54, go RESP; ack on the final counted cycle wins over timeout.
REQ-021 RESP: tx_valid = 1, tx_data stable until tx_ready; next byte presented the cycle after each transfer; after last transfer go IDLE with tx_valid = 0 the following cycle.
REQ-022 Bytes presented while rx_ready = 0 are not consumed (upstream holds them).
REQ-023 Back-to-back frames: first byte of a new frame accepted no earlier than the cycle after the final response transfer.
REQ-024 Minimum latency: last frame byte accepted at cycle N, ack at N+1 -> tx_valid first high at N+2.

Reset
REQ-025 While wb_rst_i = 0: state IDLE, counters 0, rx_ready 0, tx_valid 0, tx_data 0, wbm_cyc_o/stb_o/we_o 0, wbm_adr_o/dat_o 0, wbm_sel_o 0, busy 0.
REQ-026 Reset mid-bus-cycle drops cyc/stb immediately (asynchronous); partial frame and pending response discarded; rx_ready = 1 on first clock after release.

Structure
REQ-027 Shared package holds state encoding, command bytes 0x57/0x52, response bytes 0x4B/0x54/0x3F.
REQ-028 Single module; response byte shifter (up to 5 bytes) is the one natural sub-module, resp_shifter.

Verification
REQ-029 Write 57 30 00 00 04 DE AD BE EF, slave acks 1 cycle -> one cycle adr 30000004, dat DEADBEEF, we 1, sel F; tx 4B.
REQ-030 Read 52 30 80 00 08, slave returns 12345678 -> tx 4B 12 34 56 78, tx_ready toggled 1/0 each cycle, data held while stalled.
REQ-031 Read with no ack, ACK_TIMEOUT=4 -> cyc high exactly 4 cycles, tx 54, then IDLE.
REQ-032 Byte 0xA5 in IDLE -> tx 3F, no Wishbone cycle.
REQ-033 wb_rst_i low during BUS (cyc high) -> cyc 0 same cycle; after release new write frame completes with 4B.
REQ-034 Ack arriving exactly on ACK_TIMEOUT-th cycle -> response 4B, not 54.
